// File: rtl/adc_serial_rd_pkg.sv
// Shared definitions for the ADC serial reader: FSM states, frame layout and the frame check.
package adc_serial_rd_pkg;

   localparam int unsigned FRAME_BITS   = 16;
   localparam int unsigned LEAD_BITS    = 4;
   localparam int unsigned DATA_BITS    = 12;
   localparam int unsigned SCLK_PERIODS = FRAME_BITS;
   localparam int unsigned ERR_W        = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_DONE,
      ST_QUIET
   } adc_state_e;

   // A frame is accepted only when every leading pad bit reads back as zero.
   function automatic logic frame_ok(input logic [FRAME_BITS-1:0] bits);
      return bits[FRAME_BITS-1 -: LEAD_BITS] == '0;
   endfunction

endpackage

// File: rtl/adc_serial_rd_if.sv
// ADC pins plus the conversion-result bus between the reader and its consumer.
interface adc_serial_rd_if;
   import adc_serial_rd_pkg::*;

   logic                 en;
   logic                 adc_sdata;
   logic                 adc_cs_n;
   logic                 adc_sclk;
   logic [DATA_BITS-1:0] sample_data;
   logic                 data_valid;
   logic                 frame_err;
   logic [ERR_W-1:0]     err_cnt;

   modport master (
      input  en, adc_sdata,
      output adc_cs_n, adc_sclk, sample_data, data_valid, frame_err, err_cnt
   );

   modport slave (
      output en, adc_sdata,
      input  adc_cs_n, adc_sclk, sample_data, data_valid, frame_err, err_cnt
   );

endinterface

// File: rtl/adc_serial_rd_sclk_gen.sv
// Serial clock generator: low-then-high half periods while running, with rise and end-of-frame strobes.
module adc_serial_rd_sclk_gen
   import adc_serial_rd_pkg::*;
#(
   parameter int unsigned SCLK_HALF = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_run,
   output logic o_sclk,
   output logic o_rise,
   output logic o_last
);

   localparam int unsigned BW = $clog2(SCLK_PERIODS);

   logic [5:0]    r_half;
   logic          r_phase;
   logic [BW-1:0] r_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_half  <= '0;
         r_phase <= 1'b0;
         r_bits  <= '0;
      end else if (!i_run) begin
         r_half  <= '0;
         r_phase <= 1'b0;
         r_bits  <= '0;
      end else if (r_half == 6'(SCLK_HALF - 1)) begin
         r_half  <= '0;
         r_phase <= ~r_phase;
         if (r_phase) r_bits <= r_bits + 1'b1;
      end else begin
         r_half <= r_half + 6'd1;
      end
   end

   // Decoded from registers so the pin idles high the instant running stops or reset hits.
   assign o_sclk = ~i_run | r_phase;
   assign o_rise = i_run & r_phase & (r_half == '0);
   assign o_last = i_run & r_phase & (r_bits == BW'(SCLK_PERIODS - 1))
                 & (r_half == 6'(SCLK_HALF - 1));

endmodule

// File: rtl/adc_serial_rd.sv
// Periodic 16-bit serial ADC reader: frames a conversion, checks the pad bits, publishes 12-bit results.
module adc_serial_rd
   import adc_serial_rd_pkg::*;
#(
   parameter int unsigned SCLK_HALF     = 4,
   parameter int unsigned CS_SETUP      = 2,
   parameter int unsigned SAMPLE_PERIOD = 2000,
   parameter int unsigned QUIET         = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   adc_serial_rd_if.master bus
);

   localparam int unsigned PW = $clog2(SAMPLE_PERIOD);

   adc_state_e           r_state, w_state_nxt;
   logic [3:0]           r_tmr;
   logic [PW-1:0]        r_period;
   logic                 r_sdata_meta, r_sdata_sync;
   logic [FRAME_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_sample;
   logic                 r_valid, r_ferr;
   logic [ERR_W-1:0]     r_err_cnt;

   logic w_start, w_run, w_cs_n, w_sclk, w_rise, w_last, w_ok;

   assign w_start = bus.en & (r_period == '0) & (r_state == ST_IDLE);
   assign w_run   = (r_state == ST_SHIFT);
   assign w_cs_n  = ~((r_state == ST_SETUP) | (r_state == ST_SHIFT));
   assign w_ok    = frame_ok(r_shift);

   adc_serial_rd_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_run  (w_run),
      .o_sclk (w_sclk),
      .o_rise (w_rise),
      .o_last (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_period <= '0;
      else if (!bus.en) r_period <= '0;
      else if (r_period == PW'(SAMPLE_PERIOD - 1)) r_period <= '0;
      else r_period <= r_period + 1'b1;
   end

   // r_tmr restarts on every state change, so it times SETUP and QUIET directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= (w_state_nxt != r_state) ? '0 : r_tmr + 4'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_start) w_state_nxt = ST_SETUP;
         ST_SETUP: if (r_tmr == 4'(CS_SETUP - 1)) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_QUIET;
         ST_QUIET: if (r_tmr == 4'(QUIET - 1)) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Results are registered on the last SHIFT cycle so they appear exactly during DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sdata_meta <= 1'b0;
         r_sdata_sync <= 1'b0;
         r_shift      <= '0;
         r_sample     <= '0;
         r_valid      <= 1'b0;
         r_ferr       <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         r_sdata_meta <= bus.adc_sdata;
         r_sdata_sync <= r_sdata_meta;
         if (w_rise) r_shift <= {r_shift[FRAME_BITS-2:0], r_sdata_sync};
         r_valid <= w_last & w_ok;
         r_ferr  <= w_last & ~w_ok;
         if (w_last & w_ok) r_sample <= r_shift[DATA_BITS-1:0];
         if (w_last & ~w_ok & (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign bus.adc_cs_n    = w_cs_n;
   assign bus.adc_sclk    = w_sclk;
   assign bus.sample_data = r_sample;
   assign bus.data_valid  = r_valid;
   assign bus.frame_err   = r_ferr;
   assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_adc_serial_rd.sv
// Directed/random bench for adc_serial_rd with a cycle-indexed reference of each frame.
module tb_adc_serial_rd;
   import adc_serial_rd_pkg::*;

   localparam int unsigned SH      = 4;
   localparam int unsigned CSS     = 2;
   localparam int unsigned QT      = 4;
   localparam int unsigned P       = 200;
   localparam int unsigned CS_LAST = CSS + 32 * SH;
   localparam int unsigned DONE_AT = CS_LAST + 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adc_serial_rd_if bus();

   adc_serial_rd #(
      .SCLK_HALF     (SH),
      .CS_SETUP      (CSS),
      .SAMPLE_PERIOD (P),
      .QUIET         (QT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;
   logic [15:0] adc_word = '0;
   logic [3:0]  adc_idx  = '0;
   logic [11:0] exp_sample;
   logic [7:0]  exp_errcnt;

   // ADC model: cs_n fall arms the MSB, each sclk fall presents the next bit.
   always @(negedge bus.adc_cs_n, negedge bus.adc_sclk) begin
      if (bus.adc_sclk == 1'b0) begin
         if (!bus.adc_cs_n) begin
            bus.adc_sdata = adc_word[adc_idx];
            adc_idx = adc_idx - 4'd1;
         end
      end else begin
         adc_idx = 4'd15;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Caller sets en so that the current cycle is the start cycle T; loop covers T+1..T+len.
   task automatic run_frame(input logic [15:0] word, input int unsigned len,
                            input int unsigned drop_at, input int unsigned raise_at);
      int unsigned bad_cs = 0, bad_sclk = 0, bad_pulse = 0, rises = 0;
      logic prev_sclk, good, exp_cs, exp_sclk, exp_v, exp_e;
      logic [3:0] lead;
      lead      = word[15:12];
      good      = (lead == 4'd0);
      adc_word  = word;
      prev_sclk = 1'b1;
      for (int unsigned i = 1; i <= len; i++) begin
         step();
         if (i == drop_at) bus.en = 1'b0;
         if (i == raise_at) bus.en = 1'b1;
         exp_cs = !(i >= 1 && i <= CS_LAST);
         if (i >= 1 + CSS && i <= CS_LAST) exp_sclk = (((i - 1 - CSS) / SH) % 2) == 1;
         else exp_sclk = 1'b1;
         exp_v = (i == DONE_AT) && good;
         exp_e = (i == DONE_AT) && !good;
         if (bus.adc_cs_n !== exp_cs) bad_cs++;
         if (bus.adc_sclk !== exp_sclk) bad_sclk++;
         if (bus.data_valid !== exp_v || bus.frame_err !== exp_e) bad_pulse++;
         if (bus.adc_sclk === 1'b1 && prev_sclk === 1'b0 && bus.adc_cs_n === 1'b0) rises++;
         prev_sclk = bus.adc_sclk;
         if (i == DONE_AT) begin
            if (good) exp_sample = word[11:0];
            else if (exp_errcnt != 8'd255) exp_errcnt = exp_errcnt + 8'd1;
            check("data_valid@done", 32'(bus.data_valid), 32'(good));
            check("frame_err@done", 32'(bus.frame_err), 32'(!good));
            check("sample_data@done", 32'(bus.sample_data), 32'(exp_sample));
            check("err_cnt@done", 32'(bus.err_cnt), 32'(exp_errcnt));
         end
      end
      check("cs_n_wave_bad_cycles", bad_cs, 0);
      check("sclk_wave_bad_cycles", bad_sclk, 0);
      check("pulse_bad_cycles", bad_pulse, 0);
      check("sclk_rises", rises, 16);
   endtask

   initial begin
      logic [15:0] w;
      int unsigned lows;
      exp_sample = '0;
      exp_errcnt = '0;
      rst_n  = 1'b0;
      bus.en = 1'b0;
      repeat (3) step();
      check("rst_cs_n", 32'(bus.adc_cs_n), 1);
      check("rst_sclk", 32'(bus.adc_sclk), 1);
      check("rst_sample", 32'(bus.sample_data), 0);
      check("rst_valid", 32'(bus.data_valid), 0);
      check("rst_ferr", 32'(bus.frame_err), 0);
      check("rst_errcnt", 32'(bus.err_cnt), 0);

      rst_n = 1'b1;
      lows = 0;
      repeat (10) begin
         step();
         if (bus.adc_cs_n !== 1'b1 || bus.adc_sclk !== 1'b1) lows++;
      end
      check("idle_en0_activity", lows, 0);

      bus.en = 1'b1;
      run_frame(16'h0ABC, P, 0, 0);
      check("sample_after_abc", 32'(bus.sample_data), 32'h0ABC);
      run_frame(16'h1FFF, P, 0, 0);
      check("sample_kept_after_bad", 32'(bus.sample_data), 32'h0ABC);
      check("err_cnt_one", 32'(bus.err_cnt), 1);

      for (int k = 0; k < 6; k++) begin
         w = 16'($urandom);
         if (k % 2 == 0) w[15:12] = 4'd0;
         else if (w[15:12] == 4'd0) w[15:12] = 4'($urandom_range(1, 15));
         run_frame(w, P, 0, 0);
      end

      // en drops mid-frame: frame completes, nothing restarts.
      w = 16'($urandom);
      w[15:12] = 4'd0;
      run_frame(w, P + 50, 50, 0);
      check("en_low_cs_n_high", 32'(bus.adc_cs_n), 1);

      // en back, drop mid-frame, re-raise while busy: next start waits a full period.
      bus.en = 1'b1;
      w = 16'($urandom);
      w[15:12] = 4'd0;
      run_frame(w, 100 + P, 50, 100);
      w = 16'($urandom);
      w[15:12] = 4'd0;
      run_frame(w, P, 0, 0);

      // Reset mid-frame.
      adc_word = 16'h0555;
      repeat (70) step();
      check("cs_n_low_mid_frame", 32'(bus.adc_cs_n), 0);
      rst_n = 1'b0;
      #1;
      check("midrst_cs_n", 32'(bus.adc_cs_n), 1);
      check("midrst_sclk", 32'(bus.adc_sclk), 1);
      check("midrst_sample", 32'(bus.sample_data), 0);
      check("midrst_valid", 32'(bus.data_valid), 0);
      check("midrst_ferr", 32'(bus.frame_err), 0);
      check("midrst_errcnt", 32'(bus.err_cnt), 0);
      exp_sample = '0;
      exp_errcnt = '0;
      repeat (3) step();
      rst_n = 1'b1;
      w = 16'($urandom);
      w[15:12] = 4'd0;
      run_frame(w, P, 0, 0);

      for (int k = 0; k < 300; k++) begin
         w = 16'($urandom);
         if (w[15:12] == 4'd0) w[15:12] = 4'($urandom_range(1, 15));
         run_frame(w, P, 0, 0);
      end
      check("err_cnt_saturated", 32'(bus.err_cnt), 255);
      check("sample_kept_after_sat", 32'(bus.sample_data), 32'(exp_sample));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
